// File: rtl/ms_path_checker.sv
// rtl/ms_path_checker.sv - maze path checker downstream of the solver (optional revisit check: MS_CHK_REVISIT_EN)
module ms_path_checker #(
    parameter int MAP_DIM = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       maze,
    input  logic       out_valid,
    input  logic       maze_not_valid,
    input  logic [3:0] out_x,
    input  logic [3:0] out_y,
    output logic       chk_done,
    output logic       chk_pass,
    output logic [2:0] chk_err,
    output logic [7:0] path_len
);

    localparam int         CELLS    = MAP_DIM * MAP_DIM;
    localparam logic [7:0] LAST_BIT = 8'(CELLS - 1);
    localparam logic [3:0] COORD_LO = 4'd1;
    localparam logic [3:0] COORD_HI = 4'(MAP_DIM - 2);
    localparam logic [3:0] COORD_MAX = 4'(MAP_DIM - 1);

    localparam logic [2:0] E_NONE     = 3'd0;
    localparam logic [2:0] E_START    = 3'd1;
    localparam logic [2:0] E_NOT_ADJ  = 3'd2;
    localparam logic [2:0] E_WALL     = 3'd3;
    localparam logic [2:0] E_END      = 3'd4;
    localparam logic [2:0] E_REVISIT  = 3'd5;
    localparam logic [2:0] E_NO_PATH  = 3'd6;
    localparam logic [2:0] E_PROTOCOL = 3'd7;

    typedef enum logic [1:0] {
        S_LOAD,
        S_WAIT,
        S_CHECK,
        S_REPORT
    } state_t;

    state_t           state_q, state_d;
    logic [CELLS-1:0] map_q;
    logic [7:0]       load_cnt;
    logic [2:0]       err_q;
    logic [7:0]       len_q;
    logic [3:0]       last_x, last_y;
    logic             start_lo;
    logic             nmv_seen;

    logic             coord_ok;
    logic [7:0]       cell_idx;
    logic             is_lo, is_hi;
    logic             adj;
    logic             wall_hit;
    logic             revisit_hit;
    logic             end_ok;
    logic [2:0]       new_err;
    logic [2:0]       final_err;
    logic [4:0]       x5, y5, lx5, ly5;

    // Per-coordinate classification of the coordinate currently on the bus
    always_comb begin
        coord_ok = (out_x <= COORD_MAX) && (out_y <= COORD_MAX);
        cell_idx = coord_ok ? 8'({4'd0, out_x} * 8'(MAP_DIM) + {4'd0, out_y}) : 8'd0;
        is_lo    = (out_x == COORD_LO) && (out_y == COORD_LO);
        is_hi    = (out_x == COORD_HI) && (out_y == COORD_HI);
        wall_hit = !coord_ok || map_q[cell_idx];
        x5       = {1'b0, out_x};
        y5       = {1'b0, out_y};
        lx5      = {1'b0, last_x};
        ly5      = {1'b0, last_y};
        adj      = ((x5 == lx5) && ((y5 == ly5 + 5'd1) || (ly5 == y5 + 5'd1))) ||
                   ((y5 == ly5) && ((x5 == lx5 + 5'd1) || (lx5 == x5 + 5'd1)));
        end_ok   = start_lo ? ((last_x == COORD_HI) && (last_y == COORD_HI))
                            : ((last_x == COORD_LO) && (last_y == COORD_LO));
    end

`ifdef MS_CHK_REVISIT_EN
    logic [CELLS-1:0] visited_q;

    assign revisit_hit = coord_ok && visited_q[cell_idx];

    // Visited map: marks each in-range coordinate, wiped between mazes
    always_ff @(posedge clk) begin
        if (!rst_n || state_q == S_REPORT) begin
            visited_q <= '0;
        end else if (out_valid && coord_ok && (state_q == S_WAIT || state_q == S_CHECK)) begin
            visited_q[cell_idx] <= 1'b1;
        end
    end
`else
    assign revisit_hit = 1'b0;
`endif

    // Next state and the error raised this cycle (no-path claim dominates coordinate errors)
    always_comb begin
        state_d = state_q;
        new_err = E_NONE;
        case (state_q)
            S_LOAD: begin
                if (in_valid && load_cnt == LAST_BIT) state_d = S_WAIT;
                if (out_valid) new_err = E_PROTOCOL;
            end
            S_WAIT: begin
                if (out_valid) begin
                    state_d = S_CHECK;
                    if (maze_not_valid)      new_err = E_NO_PATH;
                    else if (!(is_lo || is_hi)) new_err = E_START;
                    else if (wall_hit)       new_err = E_WALL;
                    else if (revisit_hit)    new_err = E_REVISIT;
                end
                if (new_err == E_NONE && in_valid) new_err = E_PROTOCOL;
            end
            S_CHECK: begin
                if (!out_valid) state_d = S_REPORT;
                if (maze_not_valid) begin
                    new_err = E_NO_PATH;
                end else if (!nmv_seen) begin
                    if (out_valid) begin
                        if (!adj)             new_err = E_NOT_ADJ;
                        else if (wall_hit)    new_err = E_WALL;
                        else if (revisit_hit) new_err = E_REVISIT;
                    end else if (!end_ok) begin
                        new_err = E_END;
                    end
                end
                if (new_err == E_NONE && in_valid) new_err = E_PROTOCOL;
            end
            S_REPORT: state_d = S_LOAD;
            default:  state_d = S_LOAD;
        endcase
        final_err = (err_q != E_NONE) ? err_q : new_err;
    end

    // Map load, path tracking, first-error latch and registered report
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_LOAD;
            map_q    <= '0;
            load_cnt <= 8'd0;
            err_q    <= E_NONE;
            len_q    <= 8'd0;
            last_x   <= 4'd0;
            last_y   <= 4'd0;
            start_lo <= 1'b0;
            nmv_seen <= 1'b0;
            chk_done <= 1'b0;
            chk_pass <= 1'b0;
            chk_err  <= E_NONE;
            path_len <= 8'd0;
        end else begin
            state_q  <= state_d;
            chk_done <= 1'b0;
            if (err_q == E_NONE && new_err != E_NONE) err_q <= new_err;
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        map_q[load_cnt] <= maze;
                        load_cnt        <= (load_cnt == LAST_BIT) ? 8'd0 : load_cnt + 8'd1;
                    end
                end
                S_WAIT, S_CHECK: begin
                    if (out_valid) begin
                        if (len_q != 8'hFF) len_q <= len_q + 8'd1;
                        last_x <= out_x;
                        last_y <= out_y;
                        if (state_q == S_WAIT) start_lo <= is_lo;
                    end
                    if (maze_not_valid && (out_valid || state_q == S_CHECK)) nmv_seen <= 1'b1;
                    if (state_q == S_CHECK && !out_valid) begin
                        chk_done <= 1'b1;
                        chk_err  <= final_err;
                        chk_pass <= (final_err == E_NONE);
                        path_len <= len_q;
                    end
                end
                S_REPORT: begin
                    err_q    <= E_NONE;
                    len_q    <= 8'd0;
                    nmv_seen <= 1'b0;
                    // A bit arriving here is bit 0 of the next maze
                    if (in_valid) begin
                        map_q[0] <= maze;
                        load_cnt <= 8'd1;
                    end else begin
                        load_cnt <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ms_path_checker.sv
// tb/tb_ms_path_checker.sv - scoreboard testbench for ms_path_checker
module tb_ms_path_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       maze = 1'b0;
    logic       out_valid = 1'b0;
    logic       maze_not_valid = 1'b0;
    logic [3:0] out_x = 4'd0;
    logic [3:0] out_y = 4'd0;
    logic       chk_done;
    logic       chk_pass;
    logic [2:0] chk_err;
    logic [7:0] path_len;

    ms_path_checker #(.MAP_DIM(15)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .maze           (maze),
        .out_valid      (out_valid),
        .maze_not_valid (maze_not_valid),
        .out_x          (out_x),
        .out_y          (out_y),
        .chk_done       (chk_done),
        .chk_pass       (chk_pass),
        .chk_err        (chk_err),
        .path_len       (path_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       pass;
        logic [2:0] err;
        logic [7:0] len;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] path[$];

`ifdef MS_CHK_REVISIT_EN
    localparam logic [2:0] REVISIT_ERR = 3'd5;
    localparam logic [2:0] SAT_ERR     = 3'd5;
`else
    localparam logic [2:0] REVISIT_ERR = 3'd0;
    localparam logic [2:0] SAT_ERR     = 3'd4;
`endif

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops one expected report per chk_done pulse
    always @(negedge clk) begin : monitor
        exp_t e;
        if (chk_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got chk_done=1 at cycle %0d expected no report", cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("chk_pass", chk_pass, e.pass);
                check("chk_err", chk_err, e.err);
                check("path_len", path_len, e.len);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 1ms");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic wall_at(input int r, input int c, input int wr, input int wc);
        return (r == 0) || (r == 14) || (c == 0) || (c == 14) || (r == wr && c == wc);
    endfunction

    task automatic load_maze(input int wr, input int wc, input int prot_at);
        for (int k = 0; k < 225; k++) begin
            in_valid  = 1'b1;
            maze      = wall_at(k / 15, k % 15, wr, wc);
            out_valid = (k == prot_at);
            tick();
        end
        in_valid  = 1'b0;
        maze      = 1'b0;
        out_valid = 1'b0;
    endtask

    task automatic p_add(input int x, input int y);
        path.push_back({4'(x), 4'(y)});
    endtask

    task automatic p_std();
        path.delete();
        for (int r = 13; r >= 1; r--) p_add(r, 13);
        for (int c = 12; c >= 1; c--) p_add(1, c);
    endtask

    task automatic run_path(input logic [2:0] e_err, input logic [7:0] e_len, input logic nmv);
        exp_t e;
        for (int i = 0; i < path.size(); i++) begin
            out_valid      = 1'b1;
            out_x          = path[i][7:4];
            out_y          = path[i][3:0];
            maze_not_valid = nmv;
            tick();
        end
        out_valid      = 1'b0;
        maze_not_valid = 1'b0;
        e.pass = (e_err == 3'd0);
        e.err  = e_err;
        e.len  = e_len;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_done"}, chk_done, 0);
        check({tag, "_pass"}, chk_pass, 0);
        check({tag, "_err"}, chk_err, 0);
        check({tag, "_len"}, path_len, 0);
    endtask

    initial begin
        repeat (3) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // all-open maze, solver path from (13,13) to (1,1)
        load_maze(-1, -1, -1);
        p_std();
        run_path(3'd0, 8'd25, 1'b0);

        // jump (13,13) -> (13,11)
        load_maze(-1, -1, -1);
        p_std();
        path[1] = {4'd13, 4'd11};
        run_path(3'd2, 8'd25, 1'b0);

        // wall at (7,13), then a non-adjacent jump that must not override
        load_maze(7, 13, -1);
        path.delete();
        for (int r = 13; r >= 7; r--) p_add(r, 13);
        p_add(1, 1);
        run_path(3'd3, 8'd8, 1'b0);

        // solver claims no path for 3 coordinate cycles
        load_maze(-1, -1, -1);
        path.delete();
        for (int i = 0; i < 3; i++) p_add(0, 0);
        run_path(3'd6, 8'd3, 1'b1);

        // revisit of (5,13)
        load_maze(-1, -1, -1);
        path.delete();
        for (int r = 13; r >= 5; r--) p_add(r, 13);
        p_add(4, 13);
        p_add(5, 13);
        p_add(4, 13);
        for (int r = 3; r >= 1; r--) p_add(r, 13);
        for (int c = 12; c >= 1; c--) p_add(1, c);
        run_path(REVISIT_ERR, 8'd27, 1'b0);

        // reverse direction (1,1) -> (13,13)
        load_maze(-1, -1, -1);
        path.delete();
        for (int c = 1; c <= 13; c++) p_add(1, c);
        for (int r = 2; r <= 13; r++) p_add(r, 13);
        run_path(3'd0, 8'd25, 1'b0);

        // single coordinate stream
        load_maze(-1, -1, -1);
        path.delete();
        p_add(1, 1);
        run_path(3'd4, 8'd1, 1'b0);

        // out_valid during load, then a correct path
        load_maze(-1, -1, 100);
        p_std();
        run_path(3'd7, 8'd25, 1'b0);

        // bad start
        load_maze(-1, -1, -1);
        path.delete();
        p_add(1, 2);
        p_add(1, 1);
        run_path(3'd1, 8'd2, 1'b0);

        // path length saturation
        load_maze(-1, -1, -1);
        path.delete();
        for (int i = 0; i < 300; i++) p_add(1, (i % 2 == 0) ? 1 : 2);
        run_path(SAT_ERR, 8'd255, 1'b0);

        // reset at coordinate 10 aborts the check
        load_maze(-1, -1, -1);
        p_std();
        for (int i = 0; i < 9; i++) begin
            out_valid = 1'b1;
            out_x     = path[i][7:4];
            out_y     = path[i][3:0];
            tick();
        end
        out_x = path[9][7:4];
        out_y = path[9][3:0];
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_valid = 1'b0;
        check_outputs_zero("abort");
        repeat (4) tick();
        check("abort_no_done", chk_done, 0);

        // fresh maze and valid path after the abort
        load_maze(-1, -1, -1);
        p_std();
        run_path(3'd0, 8'd25, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("pending_reports", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
